// File: rtl/perm_scheduler_if.sv
// Requester/engine side bundle of the permutation-engine scheduler.
// master: the scheduler; slave: requesters and the engine.
interface perm_scheduler_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2,
    parameter int unsigned CNTW = 16
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] err;
    logic [IDXW-1:0] sel;
    logic            eng_rst;
    logic            eng_start;
    logic            eng_ready;
    logic            busy;
    logic [CNTW-1:0] job_count;

    modport master (
        input  req, eng_ready,
        output gnt, done, err, sel, eng_rst, eng_start, busy, job_count
    );

    modport slave (
        output req, eng_ready,
        input  gnt, done, err, sel, eng_rst, eng_start, busy, job_count
    );
endinterface

// File: rtl/perm_scheduler.sv
// Round-robin scheduler sharing one permutation engine between NREQ requesters:
// grant, clear engine, start, wait for ready under a watchdog, report done/err.
module perm_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDXW    = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNTW    = 16
) (
    input logic              clk,
    input logic              rst,
    perm_scheduler_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned SW = IDXW + 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClr   = 3'd1;
    localparam logic [2:0] StStart = 3'd2;
    localparam logic [2:0] StRun   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;
    localparam logic [2:0] StErr   = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] sel_q, sel_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CNTW-1:0] count_q, count_d;

    logic            found;
    logic [IDXW-1:0] winner;
    logic [SW-1:0]   cand;
    logic [IDXW-1:0] ptr_next;

    // First requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + SW'(k);
            if (cand >= SW'(NREQ)) begin
                cand = cand - SW'(NREQ);
            end
            if (!found && bus.req[cand[IDXW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDXW-1:0];
            end
        end
    end

    assign ptr_next = (sel_q == IDXW'(NREQ - 1)) ? '0 : sel_q + IDXW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        timer_d = timer_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    sel_d   = winner;
                    gnt_d   = NREQ'(1) << winner;
                    state_d = StClr;
                end
            end
            StClr: begin
                state_d = StStart;
            end
            StStart: begin
                timer_d = '0;
                state_d = StRun;
            end
            StRun: begin
                timer_d = timer_q + TW'(1);
                // Ready takes priority over a simultaneous watchdog expiry.
                if (bus.eng_ready) begin
                    state_d = StDone;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = StErr;
                end
            end
            StDone: begin
                count_d = count_q + CNTW'(1);
                ptr_d   = ptr_next;
                gnt_d   = '0;
                state_d = StIdle;
            end
            StErr: begin
                ptr_d   = ptr_next;
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            timer_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

    // Outputs are masked while rst is high so a killed job never reports.
    assign bus.gnt       = rst ? '0 : gnt_q;
    assign bus.sel       = sel_q;
    assign bus.done      = (!rst && state_q == StDone) ? gnt_q : '0;
    assign bus.err       = (!rst && state_q == StErr) ? gnt_q : '0;
    assign bus.eng_rst   = rst || state_q == StClr || state_q == StErr;
    assign bus.eng_start = !rst && state_q == StStart;
    assign bus.busy      = !rst && state_q != StIdle;
    assign bus.job_count = count_q;

endmodule

// File: doc/perm_scheduler.md
Name: perm_scheduler

Overview:
- Round-robin scheduler that shares one permutation engine (control unit plus datapath) between NREQ requesters.
- Selects one requester per job, selects that requester's memory through `sel`, clears the engine, issues a one-cycle start, then waits for engine ready with a watchdog.
- Returns a per-requester done or err pulse.
- Sits between the requester-side memories/clients and the engine's start/ready pins.

Parameters:
- NREQ, 4, number of requesters (2..4).
- IDXW, 2, width of `sel`; must satisfy 2^IDXW >= NREQ.
- TIMEOUT, 64, maximum cycles spent in RUN before aborting (>= 2).
- CNTW, 16, width of the completed-job counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  per-requester level request.
- gnt  output  NREQ  one-hot grant, held for the whole job.
- done  output  NREQ  one-cycle pulse on the granted bit at successful completion.
- err  output  NREQ  one-cycle pulse on the granted bit on watchdog abort.
- sel  output  IDXW  index of the granted requester; drives the engine memory mux.
- eng_rst  output  1  forces the engine back to its Idle state.
- eng_start  output  1  engine start.
- eng_ready  input  1  engine finished; the engine holds it high until cleared.
- busy  output  1  high in every state except IDLE.
- job_count  output  CNTW  number of successful jobs, wraps modulo 2^CNTW.

Behaviour:
- One clock, `clk`; reset is synchronous and active-high on `rst`.
- Reset:
  - state=IDLE, ptr=0, sel=0, gnt=0, done=0, err=0, eng_start=0, busy=0, job_count=0, timer=0.
  - eng_rst=1 in every cycle that rst is high.
  - rst has priority over all events, including mid-job; no done or err is issued for the killed job.
- States: IDLE, CLR, START, RUN, DONE, ERR. Moore outputs decoded from registered state; `sel` and `gnt` are registered.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching ptr, ptr+1, … mod NREQ.
  - At that edge: latch sel=winner, gnt=onehot(winner), go to CLR. Otherwise remain in IDLE.
  - req is sampled only in IDLE.
- CLR: eng_rst=1 for exactly 1 cycle; clears any stale Finish/ready state left by the previous job. Go to START.
- START: eng_start=1 for exactly 1 cycle; timer cleared to 0. Go to RUN.
- RUN:
  - eng_start=0; timer increments by 1 each cycle.
  - eng_ready=1 → DONE.
  - Else if timer == TIMEOUT-1 → ERR, so at most TIMEOUT RUN cycles.
  - If eng_ready rises on the same cycle the timer expires, ready wins.
- DONE:
  - done[sel]=1 for 1 cycle; job_count += 1; ptr = (sel+1) mod NREQ.
  - Go to IDLE; gnt clears at that edge.
- ERR:
  - err[sel]=1 and eng_rst=1 for 1 cycle; ptr = (sel+1) mod NREQ; job_count unchanged.
  - Go to IDLE; gnt clears.
- eng_ready is ignored in IDLE, CLR, START, DONE and ERR.
- Latency, counting the request-sampling edge as cycle 0:
  - gnt valid and eng_rst high in cycle 1; eng_start high in cycle 2; RUN from cycle 3.
  - done follows in the cycle after eng_ready is seen in RUN.
  - Minimum job is 5 cycles; back-to-back jobs have 1 IDLE cycle between them.
- A requester may drop req mid-job; the job completes and done/err still pulse.
- A requester that keeps req high competes again at the next IDLE, behind the others in round-robin order.
- gnt is one-hot or zero at all times. done and err are never both high and never high outside DONE/ERR.

Test Plan:
- Only req[2] high; engine model raises eng_ready in its 10th RUN cycle:
  - gnt=4'b0100 and eng_rst=1 at cycle 1; eng_start=1 at cycle 2 only.
  - sel=2 throughout the job; done=4'b0100 for one cycle; job_count=1; busy low afterwards.
- req=4'b1111 held constantly; engine ready after 3 RUN cycles:
  - grant sequence 0,1,2,3,0 with exactly one IDLE cycle between jobs; job_count=5 after the fifth done.
- Engine never ready, TIMEOUT=64:
  - exactly 64 RUN cycles, then err[sel] and eng_rst together for 1 cycle.
  - no done pulse; job_count unchanged; ptr advances so the next grant goes to the next pending requester.
- Engine holds eng_ready=1 from the previous job while CLR/START execute:
  - RUN is still entered and not exited before the fresh ready.
  - eng_ready rising on the exact expiry cycle produces done, not err.
- rst asserted for 2 cycles during RUN:
  - eng_rst=1 in both cycles; gnt=0, busy=0, no done/err.
  - With req=4'b1001 afterwards, req[0] is granted first because ptr=0.
- After a job for requester 3 completes (ptr wraps to 0), with req=4'b0110: requester 1 is granted.
- In the same job, dropping req[1] during RUN still yields done[1].
